data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Multi-cycle data memory with a request/ready handshake. It sits directly downstream of the CPU datapath and serves `lw` and `sw` accesses. It replaces the zero-latency data RAM so that the multi-cycle CPU can be tested against realistic memory stalls. It holds a word-addressed 32-bit array `mem`, which the bench preloads with `$readmemh`, and it reports misaligned or out-of-range accesses instead of silently aliasing them.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words in `mem`; must be a power of two, at least 4.
- LATENCY, 2, clock edges from request capture to commit; must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = write (sw), 0 = read (lw); captured with req.
- addr  input  32  byte address; captured with req.
- wdata  input  32  write data; captured with req.
- rdata  output  32  read data; valid while ready=1 after a read, and held until the next read commits.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  transaction in flight; req is ignored while this is high.
- err  output  1  asserted together with ready when the completed access was illegal.

## Operation
- States: IDLE and BUSY.
- IDLE:
  - When req=1 at an edge, capture we, addr and wdata into internal registers.
  - Load a down-counter with LATENCY-1, set busy=1 and move to BUSY.
  - If req=0, remain in IDLE.
- BUSY:
  - Each edge with counter≠0 decrements the counter.
  - At the edge where the counter is 0, commit the access, set ready=1, set busy=0 and return to IDLE.
- Commit, legal access:
  - Word index is addr[log2(DEPTH)+1:2].
  - A write performs mem[index] ← wdata; rdata is unchanged.
  - A read performs rdata ← mem[index].
  - err=0.
- Commit, illegal access: an access is illegal if addr[1:0]≠0 or addr[31:2] ≥ DEPTH.
  - No write is performed.
  - A read sets rdata ← 0.
  - err=1.
- ready and err are single-cycle pulses; they are cleared on the next edge unless another commit occurs there.
- Back-to-back transactions:
  - The cycle in which ready=1 is an IDLE cycle, so a req present on the following edge is accepted.
  - Throughput is one transaction per LATENCY+1 cycles.
- Captured addr, we and wdata are frozen during BUSY; input changes during BUSY have no effect.
- No byte or halfword accesses; only full words are supported.

## Timing
- Reset values: state IDLE, counter 0, rdata 0, ready 0, busy 0, err 0.
- The contents of `mem` are not cleared by rst.
- rst has priority over everything else. Reset during BUSY aborts the transaction:
  - no write is performed;
  - ready and err are not pulsed;
  - rdata returns to 0.
- Latency, with req high at edge t0 in IDLE:
  - busy=1 from just after t0;
  - commit at edge t0+LATENCY;
  - ready=1 for exactly the cycle after t0+LATENCY.
  - Example: with LATENCY=2, req at edge 3 gives ready high between edges 5 and 6.
- A read that immediately follows a write to the same word returns the newly written data.
- Simultaneous rst=1 and req=1: reset wins and the request is dropped.
- All outputs are registered; none depends combinationally on an input.

## Test plan
- Reset: hold rst=1 for 2 edges with random inputs, then release. Required response: rdata=0, ready=0, busy=0, err=0, and preloaded mem[4]=0x0000_00AA is still intact.
- Read latency (LATENCY=2): preload mem[1]=0x1234_5678, then pulse req=1, we=0, addr=0x4 at edge 10. Required response: busy=1 after edges 10 and 11; ready=1 and rdata=0x1234_5678 after edge 12, with err=0; ready=0 after edge 13 while rdata stays 0x1234_5678.
- Write then read back-to-back: issue a write of 0xDEAD_BEEF to addr 0x8, then on the edge where ready=1 issue a read of addr 0x8. Required response: the read returns 0xDEAD_BEEF, and there are exactly 3 cycles between the two ready pulses.
- Illegal accesses:
  - Read addr 0x6 (misaligned). Required response: ready=1, err=1, rdata=0.
  - Write 0x1 to addr 0x400 with DEPTH=256 (out of range). Required response: ready=1, err=1, and no word of mem changes.
- req while busy: raise req with a different addr during BUSY. Required response: the request is ignored, only one ready pulse occurs, and the first address's data is returned.
- Reset mid-write: issue a write of 0xFFFF_FFFF to addr 0xC, then assert rst one edge later. Required response: no ready pulse, mem[3] keeps its old value, and all outputs return to 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-addressed 32-bit data memory with a fixed multi-cycle
// latency and a req/ready handshake; illegal accesses complete with err set.
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [CW-1:0] cnt_r;
  logic          we_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   mem [DEPTH];

  logic          commit_s;
  logic          legal_s;
  logic [AW-1:0] idx_s;

  // Legal means word aligned and the word index lies inside mem (DEPTH is a power of two).
  assign idx_s    = addr_r[AW+1:2];
  assign legal_s  = (addr_r[1:0] == 2'b00) && (addr_r[31:AW+2] == {(30-AW){1'b0}});
  assign commit_s = (state_r == BUSY) && (cnt_r == {CW{1'b0}});

  // State register; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = BUSY;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Request capture, latency counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      rdata   <= 32'h0000_0000;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= commit_s;
      err   <= commit_s && !legal_s;
      busy  <= (state_nx_s == BUSY);
      if ((state_r == IDLE) && req) begin
        we_r    <= we;
        addr_r  <= addr;
        wdata_r <= wdata;
        cnt_r   <= CW'(LATENCY - 1);
      end else if ((state_r == BUSY) && (cnt_r != {CW{1'b0}})) begin
        cnt_r <= cnt_r - CW'(1);
      end
      if (commit_s && !we_r) begin
        rdata <= legal_s ? mem[idx_s] : 32'h0000_0000;
      end
    end
  end

  // Memory array is deliberately left out of reset; an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!rst && commit_s && legal_s && we_r) begin
      mem[idx_s] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: scoreboard of expected completions,
// popped whenever the DUT pulses ready.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  data_mem_ctrl #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic expect_txn(input string name, input logic is_read,
                            input logic [31:0] rd, input logic e);
    exp_t x;
    x.name = name; x.is_read = is_read; x.rdata = rd; x.err = e;
    sb.push_back(x);
  endtask

  // Called at a negedge; req is sampled on the next posedge, returns at the following negedge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
  endtask

  task automatic wait_ready(input int maxc, output int at);
    exp_t x;
    bit   found = 1'b0;
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: ready=%0b with nothing expected", ready);
      return;
    end
    x = sb.pop_front();
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_timeout: ready got 0 want 1 within %0d cycles", x.name, maxc);
      return;
    end
    if (err !== x.err) begin
      errors++;
      $display("FAIL %s_err: got %0b want %0b", x.name, err, x.err);
    end
    if (x.is_read) begin
      checks++;
      if (rdata !== x.rdata) begin
        errors++;
        $display("FAIL %s_rdata: got %h want %h", x.name, rdata, x.rdata);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      req = $urandom_range(0, 1); we = $urandom_range(0, 1);
      addr = $urandom; wdata = $urandom;
      @(negedge clk);
    end
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdata, ready, busy, err} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h ready=%0b busy=%0b err=%0b want all 0",
               rdata, ready, busy, err);
    end
    checks++;
    if (dut.mem[4] !== 32'h0000_00AA) begin
      errors++;
      $display("FAIL reset_mem4: got %h want 000000aa", dut.mem[4]);
    end
  endtask

  task automatic test_read_latency();
    int t;
    expect_txn("rd_lat", 1'b1, 32'h1234_5678, 1'b0);
    issue(1'b0, 32'h4, 32'h0);
    checks++;
    if ({busy, ready} !== 2'b10) begin
      errors++;
      $display("FAIL rd_lat_edge0: got busy=%0b ready=%0b want busy=1 ready=0", busy, ready);
    end
    @(negedge clk);
    checks++;
    if ({busy, ready} !== 2'b10) begin
      errors++;
      $display("FAIL rd_lat_edge1: got busy=%0b ready=%0b want busy=1 ready=0", busy, ready);
    end
    wait_ready(1, t);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_lat_busy_clear: got %0b want 0", busy);
    end
    @(negedge clk);
    checks++;
    if ({ready, rdata} !== {1'b0, 32'h1234_5678}) begin
      errors++;
      $display("FAIL rd_lat_hold: got ready=%0b rdata=%h want ready=0 rdata=12345678", ready, rdata);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    expect_txn("b2b_wr", 1'b0, 32'h0, 1'b0);
    issue(1'b1, 32'h8, 32'hDEAD_BEEF);
    wait_ready(8, t1);
    expect_txn("b2b_rd", 1'b1, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h8, 32'h0);
    wait_ready(8, t2);
    checks++;
    if (t2 - t1 !== 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles want 3", t2 - t1);
    end
  endtask

  task automatic test_illegal();
    int t;
    int diffs = 0;
    logic [31:0] snap [256];
    expect_txn("misaligned_rd", 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h6, 32'h0);
    wait_ready(8, t);
    for (int i = 0; i < 256; i++) snap[i] = dut.mem[i];
    expect_txn("oor_wr", 1'b0, 32'h0, 1'b1);
    issue(1'b1, 32'h400, 32'h1);
    wait_ready(8, t);
    @(negedge clk);
    checks++;
    if ({ready, err} !== 2'b00) begin
      errors++;
      $display("FAIL err_pulse_width: got ready=%0b err=%0b want 0 0", ready, err);
    end
    for (int i = 0; i < 256; i++) if (dut.mem[i] !== snap[i]) diffs++;
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL oor_mem_unchanged: got %0d changed words want 0", diffs);
    end
  endtask

  task automatic test_req_while_busy();
    exp_t x;
    int   pulses = 0;
    expect_txn("busy_rd", 1'b1, 32'h1234_5678, 1'b0);
    req = 1'b1; we = 1'b0; addr = 32'h4; wdata = 32'h0;
    @(negedge clk);
    addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    x = sb.pop_front();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_rd_ready: got %0b want 1", ready);
    end
    checks++;
    if (rdata !== x.rdata) begin
      errors++;
      $display("FAIL busy_rd_rdata: got %h want %h", rdata, x.rdata);
    end
    req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL busy_extra_ready: got %0d extra pulses want 0", pulses);
    end
  endtask

  task automatic test_reset_mid_write();
    int pulses = 0;
    issue(1'b1, 32'hC, 32'hFFFF_FFFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rdata, ready, busy, err} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_outputs: got rdata=%h ready=%0b busy=%0b err=%0b want all 0",
               rdata, ready, busy, err);
    end
    repeat (5) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_ready: got %0d pulses want 0", pulses);
    end
    checks++;
    if (dut.mem[3] !== 32'h3333_3333) begin
      errors++;
      $display("FAIL abort_mem3: got %h want 33333333", dut.mem[3]);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 256; i++) dut.mem[i] = 32'h5000_0000 + i;
    dut.mem[1] = 32'h1234_5678;
    dut.mem[3] = 32'h3333_3333;
    dut.mem[4] = 32'h0000_00AA;
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_illegal();
    test_req_while_busy();
    test_reset_mid_write();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
